// File: rtl/y86_pkg.sv
// y86_pkg: constants shared by the Y86-64 pipeline stages.
//   Instruction codes (I_HALT..I_POPQ), the "no register" specifier RNONE
//   and the default stack-pointer index.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam int RSP_IDX_DEFAULT = 4;

endpackage

// File: rtl/wb_dst_decode.sv
// wb_dst_decode: derives the write-back destinations of a retiring instruction.
//   Ports:
//     icode  in  4      instruction code
//     cnd    in  1      condition result (gates cmovXX)
//     rA, rB in  IDX_W  register specifiers
//     dst_e  out IDX_W  destination for valE (all-ones = none)
//     dst_m  out IDX_W  destination for valM (all-ones = none)
//   Purely combinational; also used by the pipeline hazard unit.
module wb_dst_decode
    import y86_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int RSP_IDX = RSP_IDX_DEFAULT
) (
    input  logic [3:0]       icode,
    input  logic             cnd,
    input  logic [IDX_W-1:0] rA,
    input  logic [IDX_W-1:0] rB,
    output logic [IDX_W-1:0] dst_e,
    output logic [IDX_W-1:0] dst_m
);

    localparam logic [IDX_W-1:0] RNONE_IDX = '1;
    localparam logic [IDX_W-1:0] RSP_SEL   = IDX_W'(RSP_IDX);

    always_comb begin
        dst_e = RNONE_IDX;
        dst_m = RNONE_IDX;

        case (icode)
            I_IRMOVQ, I_OPQ: dst_e = rB;
            // cmovXX with a false condition retires like a nop
            I_RRMOVQ: if (cnd) dst_e = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ: dst_e = RSP_SEL;
            default: dst_e = RNONE_IDX;
        endcase

        case (icode)
            I_MRMOVQ, I_POPQ: dst_m = rA;
            default: dst_m = RNONE_IDX;
        endcase
    end

endmodule

// File: rtl/y86_regfile_wb.sv
// y86_regfile_wb: Y86-64 register file with integrated write-back decode.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     wb_valid            retiring instruction present
//     icode, cnd, rA, rB  retiring instruction fields
//     valE, valM          ALU result / memory read data
//     srcA, srcB          decode read addresses
//     valA_rd, valB_rd    combinational read data (0 for RNONE / out of range)
//     regs_flat           committed registers, reg i at [i*DATA_W +: DATA_W]
//     wr_err              sticky flag: write to an index >= NREG other than RNONE
//   Optional feature macro: RF_BYPASS_EN -- same-cycle write-to-read bypass on
//   valA_rd/valB_rd (valM has priority over valE). regs_flat is never bypassed.
module y86_regfile_wb
    import y86_pkg::*;
#(
    parameter int               DATA_W   = 64,
    parameter int               NREG     = 15,
    parameter int               IDX_W    = 4,
    parameter int               RSP_IDX  = RSP_IDX_DEFAULT,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wb_valid,
    input  logic [3:0]             icode,
    input  logic                   cnd,
    input  logic [IDX_W-1:0]       rA,
    input  logic [IDX_W-1:0]       rB,
    input  logic [DATA_W-1:0]      valE,
    input  logic [DATA_W-1:0]      valM,
    input  logic [IDX_W-1:0]       srcA,
    input  logic [IDX_W-1:0]       srcB,
    output logic [DATA_W-1:0]      valA_rd,
    output logic [DATA_W-1:0]      valB_rd,
    output logic [NREG*DATA_W-1:0] regs_flat,
    output logic                   wr_err
);

    localparam logic [IDX_W-1:0] RNONE_IDX = '1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              wr_err_q;
    logic              wr_err_d;

    logic [IDX_W-1:0] dst_e;
    logic [IDX_W-1:0] dst_m;
    logic             e_ok;
    logic             m_ok;
    logic             e_bad;
    logic             m_bad;

    wb_dst_decode #(
        .IDX_W   (IDX_W),
        .RSP_IDX (RSP_IDX)
    ) u_dst_decode (
        .icode (icode),
        .cnd   (cnd),
        .rA    (rA),
        .rB    (rB),
        .dst_e (dst_e),
        .dst_m (dst_m)
    );

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return (idx != RNONE_IDX) && (32'(idx) < NREG);
    endfunction

    always_comb begin
        e_ok  = wb_valid && in_range(dst_e);
        m_ok  = wb_valid && in_range(dst_m);
        e_bad = wb_valid && (dst_e != RNONE_IDX) && !in_range(dst_e);
        m_bad = wb_valid && (dst_m != RNONE_IDX) && !in_range(dst_m);

        regs_d = regs_q;
        for (int i = 0; i < NREG; i++) begin
            if (e_ok && (32'(dst_e) == i)) regs_d[i] = valE;
            // Applied after port E so popq %rsp keeps valM
            if (m_ok && (32'(dst_m) == i)) regs_d[i] = valM;
        end

        wr_err_d = wr_err_q | e_bad | m_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
            end
            wr_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_comb begin
        valA_rd = '0;
        valB_rd = '0;
        for (int i = 0; i < NREG; i++) begin
            if ((srcA != RNONE_IDX) && (32'(srcA) == i)) valA_rd = regs_q[i];
            if ((srcB != RNONE_IDX) && (32'(srcB) == i)) valB_rd = regs_q[i];
        end
`ifdef RF_BYPASS_EN
        // e_ok/m_ok already include wb_valid and the range check
        if (m_ok && (srcA == dst_m))      valA_rd = valM;
        else if (e_ok && (srcA == dst_e)) valA_rd = valE;
        if (m_ok && (srcB == dst_m))      valB_rd = valM;
        else if (e_ok && (srcB == dst_e)) valB_rd = valE;
`endif
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_y86_regfile_wb.sv
module tb_y86_regfile_wb;

    localparam int          DW    = 64;
    localparam int          NR    = 8;
    localparam int          IW    = 4;
    localparam logic [63:0] RINIT = 64'h1000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wb_valid;
    logic [3:0]     icode;
    logic           cnd;
    logic [IW-1:0]  rA, rB;
    logic [DW-1:0]  valE, valM;
    logic [IW-1:0]  srcA, srcB;
    logic [DW-1:0]  valA_rd, valB_rd;
    logic [NR*DW-1:0] regs_flat;
    logic           wr_err;

    y86_regfile_wb #(
        .DATA_W   (DW),
        .NREG     (NR),
        .IDX_W    (IW),
        .RSP_IDX  (4),
        .RSP_INIT (RINIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .icode     (icode),
        .cnd       (cnd),
        .rA        (rA),
        .rB        (rB),
        .valE      (valE),
        .valM      (valM),
        .srcA      (srcA),
        .srcB      (srcB),
        .valA_rd   (valA_rd),
        .valB_rd   (valB_rd),
        .regs_flat (regs_flat),
        .wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural register array and sticky error bit
    logic [63:0] m_regs [NR];
    logic        m_err;
    bit          m_valid = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Destinations straight from the instruction-set rules; 15 = none
    function automatic void model_dests(input logic [3:0] ic, input logic c,
                                        input logic [3:0] a, input logic [3:0] b,
                                        output int de, output int dm);
        de = 15;
        dm = 15;
        if (ic == 4'h3 || ic == 4'h6 || (ic == 4'h2 && c)) de = int'(b);
        else if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) de = 4;
        if (ic == 4'h5 || ic == 4'hB) dm = int'(a);
    endfunction

    function automatic logic [63:0] model_read(input logic [3:0] s);
        int de, dm;
        logic [63:0] r;
        r = (int'(s) < NR) ? m_regs[s[2:0]] : 64'h0;
`ifdef RF_BYPASS_EN
        model_dests(icode, cnd, rA, rB, de, dm);
        if (wb_valid && dm < NR && int'(s) == dm)      r = valM;
        else if (wb_valid && de < NR && int'(s) == de) r = valE;
`endif
        return r;
    endfunction

    task automatic model_commit();
        int de, dm;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_regs[i] = (i == 4) ? RINIT : 64'h0;
            m_err   = 1'b0;
            m_valid = 1;
        end else if (wb_valid) begin
            model_dests(icode, cnd, rA, rB, de, dm);
            if (de < NR) m_regs[de] = valE;
            else if (de != 15) m_err = 1'b1;
            if (dm < NR) m_regs[dm] = valM;
            else if (dm != 15) m_err = 1'b1;
        end
    endtask

    task automatic check_state();
        for (int i = 0; i < NR; i++)
            check($sformatf("reg%0d", i), regs_flat[i*DW +: DW], m_regs[i]);
        check("wr_err", {63'h0, wr_err}, {63'h0, m_err});
    endtask

    task automatic drive(input logic r, input logic wv, input logic [3:0] ic, input logic c,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic [63:0] e, input logic [63:0] m,
                         input logic [3:0] sa, input logic [3:0] sb);
        rst_n = r; wb_valid = wv; icode = ic; cnd = c; rA = a; rB = b;
        valE = e; valM = m; srcA = sa; srcB = sb;
    endtask

    // Reads checked before the edge, state after it
    task automatic step();
        #2;
        if (m_valid) begin
            check("valA_rd", valA_rd, model_read(srcA));
            check("valB_rd", valB_rd, model_read(srcB));
        end
        @(posedge clk);
        model_commit();
        #1;
        if (m_valid) check_state();
    endtask

    typedef struct {
        logic        rst_n;
        logic        wb_valid;
        logic [3:0]  icode;
        logic        cnd;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valE;
        logic [63:0] valM;
        int          c1_idx;
        logic [63:0] c1_val;
        int          c2_idx;
        logic [63:0] c2_val;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        drive(0, 0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'hF, 4'hF);
        @(posedge clk);
        #1;

        //            rst wbv ic    cnd rA     rB     valE           valM          c1 val1          c2 val2       err
        vecs.push_back('{0, 1, 4'h3, 0, 4'hF, 4'h1, 64'h77,        64'h0,        4, 64'h1000,    1, 64'h0,     0});
        vecs.push_back('{1, 1, 4'h3, 0, 4'hF, 4'h2, 64'h55,        64'h0,        2, 64'h55,      4, 64'h1000,  0});
        vecs.push_back('{1, 1, 4'h2, 0, 4'h1, 4'h3, 64'h7,         64'h0,        3, 64'h0,       2, 64'h55,    0});
        vecs.push_back('{1, 1, 4'h2, 1, 4'h1, 4'h3, 64'h7,         64'h0,        3, 64'h7,       2, 64'h55,    0});
        vecs.push_back('{1, 1, 4'hB, 0, 4'h4, 4'hF, 64'h108,       64'hAB,       4, 64'hAB,      3, 64'h7,     0});
        vecs.push_back('{1, 1, 4'hB, 0, 4'h3, 4'hF, 64'h110,       64'h9,        4, 64'h110,     3, 64'h9,     0});
        vecs.push_back('{1, 0, 4'h5, 0, 4'h2, 4'h0, 64'h0,         64'hDEAD,     2, 64'h55,      4, 64'h110,   0});
        vecs.push_back('{1, 1, 4'h3, 0, 4'hF, 4'h9, 64'h99,        64'h0,        1, 64'h0,       3, 64'h9,     1});
        vecs.push_back('{1, 1, 4'h1, 0, 4'h0, 4'h0, 64'h1,         64'h2,        0, 64'h0,       2, 64'h55,    1});
        vecs.push_back('{1, 1, 4'h4, 0, 4'h1, 4'h2, 64'h3,         64'h4,        1, 64'h0,       2, 64'h55,    1});
        vecs.push_back('{0, 1, 4'h1, 0, 4'hF, 4'hF, 64'h0,         64'h0,        4, 64'h1000,    3, 64'h0,     0});
        vecs.push_back('{1, 1, 4'h3, 0, 4'hF, 4'h6, 64'h66,        64'h0,        6, 64'h66,      4, 64'h1000,  0});
        vecs.push_back('{1, 1, 4'h5, 0, 4'h0, 4'hF, 64'h0,         64'h5A,       0, 64'h5A,      6, 64'h66,    0});
        vecs.push_back('{1, 1, 4'h6, 0, 4'h1, 4'h7, 64'h12,        64'h0,        7, 64'h12,      0, 64'h5A,    0});
        vecs.push_back('{1, 1, 4'h8, 0, 4'hF, 4'hF, 64'hFF8,       64'h0,        4, 64'hFF8,     7, 64'h12,    0});
        vecs.push_back('{1, 1, 4'hA, 0, 4'h2, 4'hF, 64'hFF0,       64'h0,        4, 64'hFF0,     2, 64'h0,     0});
        vecs.push_back('{1, 1, 4'h9, 0, 4'hF, 4'hF, 64'hFF8,       64'h33,       4, 64'hFF8,     0, 64'h5A,    0});
        vecs.push_back('{1, 1, 4'h3, 0, 4'hF, 4'hF, 64'h1,         64'h0,        4, 64'hFF8,     6, 64'h66,    0});
        vecs.push_back('{1, 1, 4'h5, 0, 4'h8, 4'h0, 64'h0,         64'hBAD,      0, 64'h5A,      4, 64'hFF8,   1});
        vecs.push_back('{1, 1, 4'h0, 0, 4'h2, 4'h3, 64'hE,         64'hF,        2, 64'h0,       3, 64'h0,     1});

        foreach (vecs[k]) begin
            drive(vecs[k].rst_n, vecs[k].wb_valid, vecs[k].icode, vecs[k].cnd,
                  vecs[k].rA, vecs[k].rB, vecs[k].valE, vecs[k].valM,
                  4'(k), 4'(k * 3));
            step();
            check($sformatf("vec%0d reg%0d", k, vecs[k].c1_idx),
                  regs_flat[vecs[k].c1_idx*DW +: DW], vecs[k].c1_val);
            check($sformatf("vec%0d reg%0d", k, vecs[k].c2_idx),
                  regs_flat[vecs[k].c2_idx*DW +: DW], vecs[k].c2_val);
            check($sformatf("vec%0d wr_err", k), {63'h0, wr_err}, {63'h0, vecs[k].exp_err});
        end

        // Same-cycle read of a register being written (reg5 is 0 since reset)
        drive(1, 1, 4'h3, 0, 4'hF, 4'h5, 64'h1234, 64'h0, 4'h5, 4'h5);
        #2;
`ifdef RF_BYPASS_EN
        check("bypass valA", valA_rd, 64'h1234);
`else
        check("no-bypass valA", valA_rd, 64'h0);
`endif
        @(posedge clk);
        model_commit();
        #1;
        drive(1, 0, 4'h3, 0, 4'hF, 4'h5, 64'h0, 64'h0, 4'h5, 4'h4);
        #2;
        check("post-write valA", valA_rd, 64'h1234);
        check("post-write valB", valB_rd, 64'hFF8);
        step();

        // popq %rsp read in the same cycle: valM wins when bypassed
        drive(1, 1, 4'hB, 0, 4'h4, 4'hF, 64'h500, 64'hCAFE, 4'h4, 4'hF);
        #2;
`ifdef RF_BYPASS_EN
        check("bypass popq rsp", valA_rd, 64'hCAFE);
`else
        check("no-bypass popq rsp", valA_rd, 64'hFF8);
`endif
        check("RNONE read", valB_rd, 64'h0);
        @(posedge clk);
        model_commit();
        #1;
        check("popq rsp commit", regs_flat[4*DW +: DW], 64'hCAFE);
        check_state();

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
